shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares the single 32-bit barrel left shifter between two requesters: the ALU shift path (requester 0) and the multiply/divide unit (requester 1). Each requester presents operand and shift amount with a valid/ready handshake. The block drives the external shifter combinationally and captures the shifter output into a one-entry result register, which has its own valid/ready handshake. It sits between the execute-stage requesters and the shared shifter instance.

## Interface
- WIDTH, 32, data width; must match the shifter.
- AMT_W, 5, shift-amount width (log2 WIDTH).
- CNT_W, 16, width of the completed-operation counter.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_data  in  WIDTH  requester 0 operand.
- r0_amt  in  AMT_W  requester 0 shift amount.
- r1_valid, r1_ready, r1_data, r1_amt: same as requester 0, for requester 1.
- sh_data  out  WIDTH  operand to the shifter.
- sh_amt  out  AMT_W  shift amount to the shifter.
- sh_out  in  WIDTH  shifter result (combinational from sh_data/sh_amt).
- res_valid  out  1  result register holds a result.
- res_ready  in  1  consumer takes the result this cycle.
- res_data  out  WIDTH  shifted result.
- res_id  out  1  requester that owns res_data (0 or 1).
- busy  out  1  res_valid or any rX_valid.
- op_count  out  CNT_W  completed (accepted) operations, wraps.

## Operation
- can_accept = !res_valid | res_ready (result register empty, or being drained this cycle).
- Grant selection is combinational. With only one rX_valid high, that requester is granted. With both high, the requester other than last_grant is granted. With neither high, there is no grant.
- rX_ready = can_accept & grant==X. At most one ready is high in any cycle.
- sh_data and sh_amt carry the granted requester's operand and amount. With no grant, both are 0.
- On transfer (rX_valid & rX_ready), at the next edge:
  - res_data <= sh_out
  - res_id <= X
  - res_valid <= 1
  - last_grant <= X
  - op_count <= op_count + 1, modulo 2^CNT_W
- On drain without a new transfer (res_valid & res_ready & no grant), res_valid <= 0. res_data and res_id hold their last values.
- On simultaneous drain and accept, the new result replaces the old one, so there are no bubbles.
- While res_valid & !res_ready:
  - res_data and res_id are stable.
  - Both readys are 0.
  - Requesters must hold their valid and operands until accepted.
- Arithmetic is a pure logical left shift: zeros enter from the LSB, amt 0 passes the operand through, and bits shifted past the MSB are lost.

## Timing
- Latency is 1 cycle: an operation accepted at edge N has res_valid high after edge N.
- Throughput is 1 operation per cycle while res_ready is held high.
- Reset values: res_valid 0, res_data 0, res_id 0, op_count 0, last_grant 1 (so requester 0 wins the first tie).
- Reset asserted mid-operation clears any held result immediately (asynchronously). The dropped result is not counted. Requesters must re-present after reset.
- Round-robin guarantees bounded wait: a continuously valid requester is granted within 2 accept opportunities.
- res_ready must not combinationally depend on rX_ready, to avoid a loop. rX_ready may depend on rX_valid and res_ready.

## Configuration
- SHIFT_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties. last_grant is still updated but is unused for selection.
- SHIFT_ARB_FIXED_PRIO_EN undefined: round-robin as described in Operation.

## Test plan
- r0 only, r0_data 0x00000001, r0_amt 31, res_ready 1 -> next cycle res_valid 1, res_data 0x80000000, res_id 0, op_count 1.
- Edge amounts: 0xDEADBEEF with amt 0 -> 0xDEADBEEF; 0x0000FFFF with amt 16 -> 0xFFFF0000; 0xFFFFFFFF with amt 4 -> 0xFFFFFFF0.
- Both valid continuously with res_ready 1, 6 ops -> res_id sequence 0,1,0,1,0,1, one result per cycle. With SHIFT_ARB_FIXED_PRIO_EN -> 0,0,0,0,0,0.
- Backpressure: res_ready 0 for 3 cycles with both valid -> both readys 0 and res_data stable. Raise res_ready -> drain and the next accept happen on the same edge with no bubble.
- Reset low while res_valid 1 -> res_valid, res_data and op_count become 0 without a clock edge. After release, with both valid, the first grant is to r0.
- 2^CNT_W accepted ops -> op_count wraps to 0 on the final transfer.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Handshake/bus bundle between the two shift requesters, the shared shifter and
// the result consumer.
`default_nettype none

interface shift_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int CNT_W = 16
);
  logic             r0_valid;
  logic             r0_ready;
  logic [WIDTH-1:0] r0_data;
  logic [AMT_W-1:0] r0_amt;
  logic             r1_valid;
  logic             r1_ready;
  logic [WIDTH-1:0] r1_data;
  logic [AMT_W-1:0] r1_amt;
  logic [WIDTH-1:0] sh_data;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] sh_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  // Environment side: requesters, shifter instance and result consumer.
  modport master (
    output r0_valid, r0_data, r0_amt,
    output r1_valid, r1_data, r1_amt,
    output sh_out, res_ready,
    input  r0_ready, r1_ready, sh_data, sh_amt,
    input  res_valid, res_data, res_id, busy, op_count
  );

  modport slave (
    input  r0_valid, r0_data, r0_amt,
    input  r1_valid, r1_data, r1_amt,
    input  sh_out, res_ready,
    output r0_ready, r1_ready, sh_data, sh_amt,
    output res_valid, res_data, res_id, busy, op_count
  );
endinterface

`default_nettype wire

// File: rtl/shift_arbiter.sv
// Two-requester arbiter for one shared barrel left shifter with a one-entry result
// register. Define SHIFT_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
`default_nettype none

module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int CNT_W = 16
) (
  input  wire         clk_i,
  input  wire         rst_ni,
  shift_arbiter_if.slave bus
);

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic             res_id_q,    res_id_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] op_count_q,  op_count_d;

  logic             any_valid;
  logic             grant_id;
  logic             can_accept;
  logic             xfer;

  assign any_valid  = bus.r0_valid | bus.r1_valid;
  assign can_accept = ~res_valid_q | bus.res_ready;
  assign xfer       = any_valid & can_accept;

  // Grant id is only meaningful while any_valid is high.
  always_comb begin
    grant_id = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant_q;
`endif
    end else if (bus.r1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign bus.r0_ready = can_accept & any_valid & ~grant_id;
  assign bus.r1_ready = can_accept & any_valid &  grant_id;

  always_comb begin
    bus.sh_data = '0;
    bus.sh_amt  = '0;
    if (any_valid) begin
      bus.sh_data = grant_id ? bus.r1_data : bus.r0_data;
      bus.sh_amt  = grant_id ? bus.r1_amt  : bus.r0_amt;
    end
  end

  always_comb begin
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    if (xfer) begin
      res_valid_d  = 1'b1;
      res_data_d   = bus.sh_out;
      res_id_d     = grant_id;
      last_grant_d = grant_id;
      op_count_d   = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (bus.res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      op_count_q   <= '0;
    end else begin
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.op_count  = op_count_q;
  assign bus.busy      = res_valid_q | any_valid;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.r0_ready && bus.r1_ready));

  a_res_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (res_valid_q && !bus.res_ready) |=>
      (res_valid_q && $stable(res_data_q) && $stable(res_id_q)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; the bench also plays the shared shifter.
`default_nettype none

module tb_shift_arbiter;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  shift_arbiter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  shift_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  assign bus.sh_out = bus.sh_data << bus.sh_amt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs are driven and outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.r0_valid  = 1'b0;
    bus.r0_data   = '0;
    bus.r0_amt    = '0;
    bus.r1_valid  = 1'b0;
    bus.r1_data   = '0;
    bus.r1_amt    = '0;
    bus.res_ready = 1'b1;
  endtask

  logic [31:0] vec_d [4] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [4:0]  vec_a [4] = '{5'd31, 5'd0, 5'd16, 5'd4};
  logic [31:0] vec_r [4] = '{32'h8000_0000, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'hFFFF_FFF0};

  int exp_cnt;
  logic exp_id;
  logic [31:0] held_data;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  bus.res_data,       32'd0);
    chk("rst_res_id",    32'(bus.res_id),    32'd0);
    chk("rst_op_count",  32'(bus.op_count),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    rst_n = 1'b1;
    step();

    // Tie-breaking: r0 -> 1<<0 = 1, r1 -> 3<<2 = 0xC
    bus.r0_valid = 1'b1; bus.r0_data = 32'h1; bus.r0_amt = 5'd0;
    bus.r1_valid = 1'b1; bus.r1_data = 32'h3; bus.r1_amt = 5'd2;
    for (int i = 0; i < 6; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = (i % 2 == 1);
`endif
      step();
      exp_cnt++;
      chk($sformatf("rr%0d_valid", i), 32'(bus.res_valid), 32'd1);
      chk($sformatf("rr%0d_id", i),    32'(bus.res_id),    32'(exp_id));
      chk($sformatf("rr%0d_data", i),  bus.res_data,       exp_id ? 32'hC : 32'h1);
      chk($sformatf("rr%0d_cnt", i),   32'(bus.op_count),  32'(exp_cnt));
    end

    // Backpressure with both requesters waiting
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    held_data = 32'h1;
`else
    held_data = 32'hC;
`endif
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_r0_ready", i), 32'(bus.r0_ready), 32'd0);
      chk($sformatf("bp%0d_r1_ready", i), 32'(bus.r1_ready), 32'd0);
      step();
      chk($sformatf("bp%0d_data", i),  bus.res_data,      held_data);
      chk($sformatf("bp%0d_valid", i), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp%0d_cnt", i),   32'(bus.op_count),  32'(exp_cnt));
    end
    bus.res_ready = 1'b1;
    #1;
    chk("bp_release_r0_ready", 32'(bus.r0_ready), 32'd1);
    chk("bp_release_r1_ready", 32'(bus.r1_ready), 32'd0);
    step();
    exp_cnt++;
    chk("bp_nobubble_valid", 32'(bus.res_valid), 32'd1);
    chk("bp_nobubble_id",    32'(bus.res_id),    32'd0);
    chk("bp_nobubble_data",  bus.res_data,       32'h1);
    chk("bp_nobubble_cnt",   32'(bus.op_count),  32'(exp_cnt));
    idle_inputs();
    #1;
    chk("idle_sh_data", bus.sh_data,       32'd0);
    chk("idle_sh_amt",  32'(bus.sh_amt),   32'd0);
    step();
    chk("drain_valid", 32'(bus.res_valid), 32'd0);
    chk("drain_hold",  bus.res_data,       32'h1);
    chk("drain_busy",  32'(bus.busy),      32'd0);

    // Requester 0 alone, edge shift amounts
    for (int i = 0; i < 4; i++) begin
      bus.r0_valid = 1'b1; bus.r0_data = vec_d[i]; bus.r0_amt = vec_a[i];
      #1;
      chk($sformatf("v%0d_sh_data", i), bus.sh_data, vec_d[i]);
      step();
      exp_cnt++;
      chk($sformatf("v%0d_data", i), bus.res_data,      vec_r[i]);
      chk($sformatf("v%0d_id", i),   32'(bus.res_id),   32'd0);
      chk($sformatf("v%0d_cnt", i),  32'(bus.op_count), 32'(exp_cnt));
    end

    // Requester 1 alone
    idle_inputs();
    bus.r1_valid = 1'b1; bus.r1_data = 32'h1234_5678; bus.r1_amt = 5'd8;
    #1;
    chk("r1_only_ready", 32'(bus.r1_ready), 32'd1);
    step();
    exp_cnt++;
    chk("r1_only_data", bus.res_data,      32'h3456_7800);
    chk("r1_only_id",   32'(bus.res_id),   32'd1);
    chk("r1_only_cnt",  32'(bus.op_count), 32'(exp_cnt));

    // Asynchronous reset with a held result
    idle_inputs();
    bus.res_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("async_rst_data",  bus.res_data,       32'd0);
    chk("async_rst_cnt",   32'(bus.op_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    bus.r0_valid = 1'b1; bus.r0_data = 32'h5; bus.r0_amt = 5'd1;
    bus.r1_valid = 1'b1; bus.r1_data = 32'h7; bus.r1_amt = 5'd1;
    #1;
    chk("post_rst_r0_ready", 32'(bus.r0_ready), 32'd1);
    chk("post_rst_r1_ready", 32'(bus.r1_ready), 32'd0);
    step();
    chk("post_rst_id",   32'(bus.res_id),   32'd0);
    chk("post_rst_data", bus.res_data,      32'hA);
    chk("post_rst_cnt",  32'(bus.op_count), 32'd1);

    // Counter wrap: one transfer per cycle from r0 alone
    bus.r1_valid = 1'b0;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("wrap_pre_cnt", 32'(bus.op_count), 32'h0000_FFFF);
    step();
    chk("wrap_cnt",   32'(bus.op_count),  32'd0);
    chk("wrap_valid", 32'(bus.res_valid), 32'd1);

    idle_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
